mpsoc_msi_slave_arbiter: RTL and testbench
==========================================

Name: mpsoc_msi_slave_arbiter

Overview:
Per-slave-port arbiter for the AHB-Lite multi-master interconnect. One instance per slave port; it decides which master owns that slave.
- Arbitration is 3-bit priority based, with round-robin among masters of equal top priority.
- It honours bus locking (HMASTLOCK), master can_switch hints and the AHB-Lite transfer boundary given by HREADY.
- It produces the registered one-hot grant vector that drives the slave-port multiplexers and the per-master grant feedback.

Parameters:
MASTERS, 5, number of requesting masters (2..16)
QUANTUM, 16, max consecutive HREADY-qualified transfers before forced re-arbitration (used only with the optional feature)

Ports:
HCLK  input  1  clock, rising edge
HRESET  input  1  synchronous, active-high reset
mst_priority  input  MASTERS x 3  per-master priority, 7 = highest
mst_HSEL  input  MASTERS  master m selects this slave
mst_HTRANS  input  MASTERS x 2  master transfer type; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
mst_HMASTLOCK  input  MASTERS  master m requests a locked sequence
can_switch  input  MASTERS  master m is at a point where ownership may move
slv_HREADY  input  1  transfer-complete from the slave side
granted_master  output  MASTERS  registered one-hot grant; all zero when no owner
grant_idx  output  clog2(MASTERS)  binary index of the owner; 0 when no owner
grant_valid  output  1  an owner exists (OR of granted_master)
grant_change  output  1  one-cycle pulse in the cycle after granted_master changed value

Behaviour:
- Request: req[m] = mst_HSEL[m] & mst_HTRANS[m][1], i.e. NONSEQ or SEQ.
- Reset (HRESET=1 at a clock edge):
  - granted_master=0, grant_idx=0, grant_valid=0, grant_change=0.
  - state=IDLE; rr_ptr=0; quantum counter=0.
- States:
  - IDLE: no owner.
  - OWNED: owner holds the grant, unlocked.
  - LOCKED: owner holds the grant with HMASTLOCK asserted.
- Arbitration event (evaluated at a clock edge, every condition required):
  - slv_HREADY=1, and
  - state=IDLE, or state=OWNED with (can_switch[owner]=1 or req[owner]=0).
  - In LOCKED, no arbitration happens. LOCKED leaves to OWNED on the first HREADY=1 cycle with HMASTLOCK[owner]=0.
- Winner selection:
  - P = max mst_priority over requesting masters.
  - Among requesters with priority P, pick the first index at or after rr_ptr, wrapping from MASTERS-1 to 0.
  - rr_ptr becomes (winner+1) mod MASTERS only when the grant actually moves to a different master.
- Owner with no requester present:
  - No requesters and owner still at can_switch=1 or not requesting: grant is released, go to IDLE, granted_master=0.
  - Owner still requesting and no other requester: owner keeps the grant, no change pulse.
- Entering LOCKED: at an arbitration event where the winner has HMASTLOCK=1, next state is LOCKED instead of OWNED.
- Latency:
  - Decision is made combinationally at an edge; granted_master updates at that same edge (registered output), visible in the following cycle.
  - grant_change is high for exactly the one cycle after granted_master changed value, then returns to 0.
- slv_HREADY=0: every state and output holds. This also applies to a lock request with HREADY low.
- Simultaneous events:
  - Owner deasserts request while a higher-priority master requests: the higher-priority master wins at the same edge.
  - Equal-priority ties always resolve by rr_ptr.
- Reset mid-transfer: grant drops to 0 at that edge regardless of LOCKED or HREADY.
- Priority width is fixed at 3 bits. Comparison is unsigned.

Optional Feature:
MSI_ARB_QUANTUM_EN
- Defined:
  - A counter clears when the grant moves and increments on each HREADY=1 cycle in OWNED.
  - When the counter reaches QUANTUM and another master requests with priority >= the owner's, an arbitration event is forced even without can_switch. The owner is excluded from that round.
  - LOCKED is never pre-empted.
  - Counter saturates at QUANTUM.
- Undefined: no counter, no forced hand-over; QUANTUM is ignored.

Test Plan:
- Reset, then req[2] with priority 3 and HREADY=1 → next cycle granted_master=00100, grant_idx=2, grant_change=1 for exactly one cycle.
- Owner m2 (priority 3) with can_switch=1; m4 requests with priority 6 → grant moves to m4 at that edge. With can_switch=0 instead → grant stays on m2 until can_switch=1.
- m0, m1, m3 all request with priority 5, each releasing via can_switch → grant sequence m0 → m1 → m3 → m0 (round-robin wrap).
- m1 wins with HMASTLOCK=1; m4 requests with priority 7 → m1 holds the grant until an HREADY=1 cycle with HMASTLOCK=0, then m4 is granted.
- slv_HREADY=0 while a higher-priority request arrives → grant unchanged until HREADY=1. Assert HRESET while LOCKED → granted_master=0 and grant_valid=0 at the next edge.
- With MSI_ARB_QUANTUM_EN and QUANTUM=4: m0 streams with can_switch=0; m2 requests at equal priority → grant moves to m2 after the 4th HREADY cycle. Without the macro → m0 keeps the grant indefinitely.

Source files
------------

// File: rtl/mpsoc_msi_slave_arbiter_if.sv
// ---------------------------------------------------------------------------
// mpsoc_msi_slave_arbiter_if
//
// Purpose: bundles the request side and the grant side of one slave-port
// arbiter so the interconnect can hand it around as a single port.
//
// Signals (MASTERS = number of requesting masters):
//   mst_priority   [MASTERS][3]  per-master priority, 7 = highest
//   mst_HSEL       [MASTERS]     master m selects this slave
//   mst_HTRANS     [MASTERS][2]  master transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   mst_HMASTLOCK  [MASTERS]     master m requests a locked sequence
//   can_switch     [MASTERS]     master m may give up ownership now
//   slv_HREADY                   transfer complete on the slave side
//   granted_master [MASTERS]     registered one-hot grant
//   grant_idx      [clog2]       binary owner index, 0 when no owner
//   grant_valid                  an owner exists
//   grant_change                 one-cycle pulse after the grant changed
//
// Modports:
//   master : the interconnect / masters side (drives requests, sees grants)
//   slave  : the arbiter itself (sees requests, drives grants)
// ---------------------------------------------------------------------------
interface mpsoc_msi_slave_arbiter_if #(
  parameter int MASTERS = 5
);
  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  logic [MASTERS-1:0][2:0] mst_priority;
  logic [MASTERS-1:0]      mst_HSEL;
  logic [MASTERS-1:0][1:0] mst_HTRANS;
  logic [MASTERS-1:0]      mst_HMASTLOCK;
  logic [MASTERS-1:0]      can_switch;
  logic                    slv_HREADY;
  logic [MASTERS-1:0]      granted_master;
  logic [IW-1:0]           grant_idx;
  logic                    grant_valid;
  logic                    grant_change;

  modport master (
    output mst_priority, mst_HSEL, mst_HTRANS, mst_HMASTLOCK, can_switch,
    output slv_HREADY,
    input  granted_master, grant_idx, grant_valid, grant_change
  );

  modport slave (
    input  mst_priority, mst_HSEL, mst_HTRANS, mst_HMASTLOCK, can_switch,
    input  slv_HREADY,
    output granted_master, grant_idx, grant_valid, grant_change
  );
endinterface

// File: rtl/mpsoc_msi_slave_arbiter.sv
// ---------------------------------------------------------------------------
// mpsoc_msi_slave_arbiter
//
// Purpose: per-slave-port arbiter of the AHB-Lite multi-master interconnect.
// Picks the owner of this slave by 3-bit priority with round-robin among
// equal top priorities, honours HMASTLOCK, can_switch and the HREADY
// transfer boundary, and drives a registered one-hot grant.
//
// Ports:
//   HCLK    clock, rising edge
//   HRESET  synchronous, active-high reset
//   bus     mpsoc_msi_slave_arbiter_if.slave (requests in, grants out)
//
// Parameters:
//   MASTERS  number of requesting masters (2..16)
//   QUANTUM  max consecutive HREADY cycles in OWNED before a forced
//            hand-over (only with MSI_ARB_QUANTUM_EN)
//
// Optional feature macro: MSI_ARB_QUANTUM_EN
//   Defined   : an owner that has held the slave for QUANTUM HREADY cycles
//               is pre-empted by any other requester of priority >= its own,
//               even without can_switch (never while LOCKED).
//   Undefined : no quantum counter; QUANTUM is ignored.
// ---------------------------------------------------------------------------
module mpsoc_msi_slave_arbiter #(
  parameter int MASTERS = 5,
  parameter int QUANTUM = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  mpsoc_msi_slave_arbiter_if.slave bus
);
  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_reg;
  logic [MASTERS-1:0] granted_reg;
  logic [IW-1:0]      grant_idx_reg;
  logic [IW-1:0]      rr_ptr_reg;
  logic               grant_change_reg;

  logic [MASTERS-1:0] req;
  logic [MASTERS-1:0] htrans_lsb;
  logic [MASTERS-1:0] cand;
  logic [MASTERS-1:0] is_top;
  logic [MASTERS-1:0] at_or_after;
  logic [MASTERS-1:0] top_hi;
  logic [MASTERS-1:0] pick;
  logic [MASTERS-1:0] win_onehot;
  logic [MASTERS:0][2:0]    max_chain;
  logic [MASTERS:0][IW-1:0] idx_chain;
  logic [2:0]         top_pri;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      rr_ptr_next;
  logic               win_found;
  logic               win_lock;
  logic               owner_can_switch;
  logic               owner_req;
  logic               owner_lock;
  logic               normal_arb;
  logic               force_arb;
  logic               excl_owner;
  logic               arb_event;
  logic               grant_move;

  // Only NONSEQ/SEQ count as a request, so the low HTRANS bit is not needed.
  generate
    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_req
      assign req[gi]        = bus.mst_HSEL[gi] & bus.mst_HTRANS[gi][1];
      assign htrans_lsb[gi] = bus.mst_HTRANS[gi][0];
    end
  endgenerate

  logic htrans_lsb_unused;
  assign htrans_lsb_unused = ^htrans_lsb;

  // Owner attributes are read through the one-hot grant, which is all-zero
  // in IDLE, so no index decode is needed.
  assign owner_can_switch = |(granted_reg & bus.can_switch);
  assign owner_req        = |(granted_reg & req);
  assign owner_lock       = |(granted_reg & bus.mst_HMASTLOCK);

`ifdef MSI_ARB_QUANTUM_EN
  localparam int QW = $clog2(QUANTUM + 1);

  logic [QW-1:0]      quantum_cnt_reg;
  logic [MASTERS-1:0] contender;
  logic [MASTERS:0][2:0] owner_pri_chain;
  logic [2:0]         owner_pri;

  generate
    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_quantum
      assign owner_pri_chain[gi+1] = owner_pri_chain[gi] |
                                     (granted_reg[gi] ? bus.mst_priority[gi] : 3'd0);
      assign contender[gi] = req[gi] & ~granted_reg[gi] &
                             (bus.mst_priority[gi] >= owner_pri);
    end
  endgenerate
  assign owner_pri_chain[0] = 3'd0;
  assign owner_pri          = owner_pri_chain[MASTERS];

  assign force_arb = (state_reg == ST_OWNED) &&
                     (quantum_cnt_reg == QW'(QUANTUM)) && (|contender);

  // Counts HREADY cycles of the current owner in OWNED, saturating at QUANTUM.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      quantum_cnt_reg <= '0;
    end else if (grant_move) begin
      quantum_cnt_reg <= '0;
    end else if (bus.slv_HREADY && (state_reg == ST_OWNED) &&
                 (quantum_cnt_reg != QW'(QUANTUM))) begin
      quantum_cnt_reg <= quantum_cnt_reg + QW'(1);
    end
  end
`else
  logic [31:0] quantum_unused;
  assign quantum_unused = 32'(QUANTUM);
  assign force_arb      = 1'b0;
`endif

  // A forced (quantum) round must hand the slave to someone else, so the
  // owner drops out of the candidate set unless it offered to switch anyway.
  assign normal_arb = (state_reg == ST_IDLE) ||
                      ((state_reg == ST_OWNED) && (owner_can_switch || !owner_req));
  assign excl_owner = force_arb & ~owner_can_switch;
  assign arb_event  = bus.slv_HREADY & (normal_arb | force_arb);
  assign cand       = excl_owner ? (req & ~granted_reg) : req;

  // Top priority among candidates, then round-robin among those at the top:
  // prefer the lowest set bit at or above rr_ptr, else wrap to the lowest.
  generate
    for (genvar gi = 0; gi < MASTERS; gi++) begin : g_sel
      assign max_chain[gi+1] = (cand[gi] && (bus.mst_priority[gi] > max_chain[gi])) ?
                               bus.mst_priority[gi] : max_chain[gi];
      assign is_top[gi]      = cand[gi] & (bus.mst_priority[gi] == top_pri);
      assign at_or_after[gi] = (IW'(gi) >= rr_ptr_reg);
      assign idx_chain[gi+1] = idx_chain[gi] | (win_onehot[gi] ? IW'(gi) : '0);
    end
  endgenerate
  assign max_chain[0] = 3'd0;
  assign idx_chain[0] = '0;
  assign top_pri      = max_chain[MASTERS];
  assign top_hi       = is_top & at_or_after;
  assign pick         = (|top_hi) ? top_hi : is_top;
  assign win_onehot   = pick & (~pick + MASTERS'(1));
  assign win_found    = |pick;
  assign win_idx      = idx_chain[MASTERS];
  assign win_lock     = |(win_onehot & bus.mst_HMASTLOCK);
  assign rr_ptr_next  = (win_idx == IW'(MASTERS - 1)) ? '0 : (win_idx + IW'(1));

  // The grant "moves" when the registered one-hot takes a different value,
  // including a release to no owner.
  assign grant_move = arb_event &&
                      (win_found ? (win_onehot != granted_reg) : (granted_reg != '0));

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg        <= ST_IDLE;
      granted_reg      <= '0;
      grant_idx_reg    <= '0;
      rr_ptr_reg       <= '0;
      grant_change_reg <= 1'b0;
    end else begin
      grant_change_reg <= grant_move;
      if (bus.slv_HREADY) begin
        case (state_reg)
          ST_LOCKED: begin
            // No arbitration while locked; unlocking only returns to OWNED.
            if (!owner_lock) begin
              state_reg <= ST_OWNED;
            end
          end
          default: begin
            if (arb_event) begin
              if (win_found) begin
                state_reg     <= win_lock ? ST_LOCKED : ST_OWNED;
                granted_reg   <= win_onehot;
                grant_idx_reg <= win_idx;
                if (grant_move) begin
                  rr_ptr_reg <= rr_ptr_next;
                end
              end else begin
                state_reg     <= ST_IDLE;
                granted_reg   <= '0;
                grant_idx_reg <= '0;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.granted_master = granted_reg;
  assign bus.grant_idx      = grant_idx_reg;
  assign bus.grant_valid    = |granted_reg;
  assign bus.grant_change   = grant_change_reg;

endmodule

// File: tb/tb_mpsoc_msi_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mpsoc_msi_slave_arbiter
//
// Directed vector table, a quantum hand-over sequence and a random phase,
// all cross-checked every cycle against a behavioural ownership model.
// ---------------------------------------------------------------------------
module tb_mpsoc_msi_slave_arbiter;
  localparam int N  = 5;
  localparam int Q  = 4;

  logic HCLK = 1'b0;
  logic HRESET;

  always #5 HCLK = ~HCLK;

  mpsoc_msi_slave_arbiter_if #(.MASTERS(N)) ifc();

  mpsoc_msi_slave_arbiter #(.MASTERS(N), .QUANTUM(Q)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (ifc)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           rst;
    logic           rdy;
    logic [N-1:0]   req;
    logic [3*N-1:0] pri;
    logic [N-1:0]   lock;
    logic [N-1:0]   cs;
    logic [N-1:0]   exp_gm;
    int             exp_idx;
    logic           exp_chg;
  } vec_t;

  vec_t vecs[$];

  // Reference model: who owns the slave, whether locked, round-robin start.
  int m_owner = -1;
  int m_rr    = 0;
  int m_cnt   = 0;
  bit m_locked = 1'b0;
  bit m_chg    = 1'b0;

  function automatic logic [3*N-1:0] pri5(input int p0, input int p1, input int p2,
                                          input int p3, input int p4);
    return {3'(p4), 3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  function automatic void add(input logic rst, input logic rdy, input logic [N-1:0] req,
                              input logic [3*N-1:0] pri, input logic [N-1:0] lock,
                              input logic [N-1:0] cs, input logic [N-1:0] gm,
                              input int idx, input logic chg);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.req = req; v.pri = pri; v.lock = lock; v.cs = cs;
    v.exp_gm = gm; v.exp_idx = idx; v.exp_chg = chg;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Requests use NONSEQ/SEQ; non-requests mix HSEL=1 with BUSY and HSEL=0.
  task automatic drive(input logic rdy, input logic [N-1:0] req, input logic [3*N-1:0] pri,
                       input logic [N-1:0] lock, input logic [N-1:0] cs);
    ifc.slv_HREADY = rdy;
    for (int m = 0; m < N; m++) begin
      ifc.mst_HSEL[m]     = req[m] | ~m[0];
      ifc.mst_HTRANS[m]   = req[m] ? {1'b1, m[0]} : {1'b0, ~m[0]};
      ifc.mst_priority[m] = pri[3*m +: 3];
    end
    ifc.mst_HMASTLOCK = lock;
    ifc.can_switch    = cs;
  endtask

  function automatic bit rq(input int m);
    return ifc.mst_HSEL[m] & ifc.mst_HTRANS[m][1];
  endfunction

  function automatic int pr(input int m);
    return int'(ifc.mst_priority[m]);
  endfunction

  // Next ownership from the rules: scan masters in round-robin order from
  // m_rr, keep the first one seen with strictly the highest priority.
  task automatic model_edge(input logic rst);
    int prev;
    int best;
    bit was_owned;
    bit normal;
    bit forced;
    bit excl;
    prev      = m_owner;
    was_owned = (m_owner >= 0) && !m_locked;
    if (rst) begin
      m_owner = -1; m_locked = 1'b0; m_rr = 0; m_cnt = 0; m_chg = 1'b0;
      return;
    end
    m_chg = 1'b0;
    if (!ifc.slv_HREADY) return;
    if (m_locked) begin
      if (!ifc.mst_HMASTLOCK[m_owner]) m_locked = 1'b0;
      return;
    end
    normal = (m_owner < 0) || ifc.can_switch[m_owner] || !rq(m_owner);
    forced = 1'b0;
`ifdef MSI_ARB_QUANTUM_EN
    if (m_owner >= 0 && m_cnt == Q) begin
      for (int m = 0; m < N; m++) begin
        if (m != m_owner && rq(m) && pr(m) >= pr(m_owner)) forced = 1'b1;
      end
    end
`endif
    excl = forced && !normal;
    if (normal || forced) begin
      best = -1;
      for (int k = 0; k < N; k++) begin
        int m;
        m = (m_rr + k) % N;
        if (rq(m) && !(excl && m == m_owner) && (best < 0 || pr(m) > pr(best))) best = m;
      end
      if (best < 0) begin
        m_owner = -1;
      end else begin
        if (best != m_owner) begin
          m_owner = best;
          m_rr    = (best + 1) % N;
        end
        m_locked = ifc.mst_HMASTLOCK[best];
      end
    end
    if (m_owner != prev) m_cnt = 0;
    else if (was_owned && m_cnt < Q) m_cnt++;
    m_chg = (m_owner != prev);
  endtask

  task automatic tick(input logic rst);
    HRESET = rst;
    model_edge(rst);
    @(posedge HCLK);
    #1;
    chk("model_gm",    32'(ifc.granted_master), (m_owner < 0) ? 0 : (1 << m_owner));
    chk("model_idx",   32'(ifc.grant_idx),      (m_owner < 0) ? 0 : m_owner);
    chk("model_valid", 32'(ifc.grant_valid),    32'(m_owner >= 0));
    chk("model_chg",   32'(ifc.grant_change),   32'(m_chg));
  endtask

  initial begin
    HRESET = 1'b1;
    drive(1'b1, '0, '0, '0, '0);

    //   rst  rdy  req       priority            lock      cs        exp_gm   idx chg
    add(1, 1, 5'b00000, pri5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 0, 0);
    add(0, 1, 5'b00100, pri5(0,0,3,0,0), 5'b00000, 5'b00000, 5'b00100, 2, 1);
    add(0, 1, 5'b00100, pri5(0,0,3,0,0), 5'b00000, 5'b00000, 5'b00100, 2, 0);
    add(0, 1, 5'b10100, pri5(0,0,3,0,6), 5'b00000, 5'b00000, 5'b00100, 2, 0);
    add(0, 1, 5'b10100, pri5(0,0,3,0,6), 5'b00000, 5'b00000, 5'b00100, 2, 0);
    add(0, 1, 5'b10100, pri5(0,0,3,0,6), 5'b00000, 5'b00100, 5'b10000, 4, 1);
    add(0, 1, 5'b00000, pri5(0,0,3,0,6), 5'b00000, 5'b00000, 5'b00000, 0, 1);
    add(0, 1, 5'b00000, pri5(0,0,3,0,6), 5'b00000, 5'b00000, 5'b00000, 0, 0);
    add(0, 1, 5'b01011, pri5(5,5,0,5,0), 5'b00000, 5'b00000, 5'b00001, 0, 1);
    add(0, 1, 5'b01011, pri5(5,5,0,5,0), 5'b00000, 5'b00001, 5'b00010, 1, 1);
    add(0, 1, 5'b01011, pri5(5,5,0,5,0), 5'b00000, 5'b00010, 5'b01000, 3, 1);
    add(0, 1, 5'b01011, pri5(5,5,0,5,0), 5'b00000, 5'b01000, 5'b00001, 0, 1);
    add(0, 1, 5'b01011, pri5(5,5,0,5,0), 5'b00000, 5'b00000, 5'b00001, 0, 0);
    add(0, 1, 5'b00000, pri5(5,5,0,5,0), 5'b00000, 5'b00000, 5'b00000, 0, 1);
    add(0, 1, 5'b00010, pri5(0,2,0,0,0), 5'b00010, 5'b00000, 5'b00010, 1, 1);
    add(0, 1, 5'b10010, pri5(0,2,0,0,7), 5'b00010, 5'b11111, 5'b00010, 1, 0);
    add(0, 0, 5'b10010, pri5(0,2,0,0,7), 5'b00000, 5'b11111, 5'b00010, 1, 0);
    add(0, 1, 5'b10010, pri5(0,2,0,0,7), 5'b00000, 5'b11111, 5'b00010, 1, 0);
    add(0, 1, 5'b10010, pri5(0,2,0,0,7), 5'b00000, 5'b11111, 5'b10000, 4, 1);
    add(0, 0, 5'b10010, pri5(0,6,0,0,1), 5'b00000, 5'b11111, 5'b10000, 4, 0);
    add(0, 1, 5'b10010, pri5(0,6,0,0,1), 5'b00000, 5'b11111, 5'b00010, 1, 1);
    add(0, 1, 5'b00010, pri5(0,6,0,0,1), 5'b00010, 5'b00010, 5'b00010, 1, 0);
    add(0, 1, 5'b10010, pri5(0,6,0,0,7), 5'b00010, 5'b11111, 5'b00010, 1, 0);
    add(1, 0, 5'b10010, pri5(0,6,0,0,7), 5'b00010, 5'b11111, 5'b00000, 0, 0);
    add(0, 1, 5'b00000, pri5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, 0, 0);
    add(0, 0, 5'b00100, pri5(0,0,3,0,0), 5'b00000, 5'b00000, 5'b00000, 0, 0);
    add(0, 1, 5'b00100, pri5(0,0,3,0,0), 5'b00000, 5'b00000, 5'b00100, 2, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].req, vecs[i].pri, vecs[i].lock, vecs[i].cs);
      tick(vecs[i].rst);
      $display("vec %0d: req=%b rdy=%b gm=%b idx=%0d chg=%b", i, vecs[i].req, vecs[i].rdy,
               ifc.granted_master, ifc.grant_idx, ifc.grant_change);
      chk($sformatf("vec%0d_gm", i),    32'(ifc.granted_master), 32'(vecs[i].exp_gm));
      chk($sformatf("vec%0d_idx", i),   32'(ifc.grant_idx),      vecs[i].exp_idx);
      chk($sformatf("vec%0d_valid", i), 32'(ifc.grant_valid),    32'(|vecs[i].exp_gm));
      chk($sformatf("vec%0d_chg", i),   32'(ifc.grant_change),   32'(vecs[i].exp_chg));
    end

    // Quantum: m0 streams without can_switch, m2 joins at equal priority.
    drive(1'b1, '0, '0, '0, '0);
    tick(1'b1);
    drive(1'b1, 5'b00001, pri5(4,0,4,0,0), 5'b00000, 5'b00000);
    tick(1'b0);
    chk("q_first", 32'(ifc.granted_master), 32'h1);
    drive(1'b1, 5'b00101, pri5(4,0,4,0,0), 5'b00000, 5'b00000);
`ifdef MSI_ARB_QUANTUM_EN
    for (int i = 1; i <= Q; i++) begin
      tick(1'b0);
      $display("quantum %0d: gm=%b", i, ifc.granted_master);
      chk($sformatf("q_hold%0d", i), 32'(ifc.granted_master), 32'h1);
    end
    tick(1'b0);
    $display("quantum move: gm=%b chg=%b", ifc.granted_master, ifc.grant_change);
    chk("q_move",     32'(ifc.granted_master), 32'h4);
    chk("q_move_chg", 32'(ifc.grant_change),   32'h1);
`else
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      $display("quantum %0d: gm=%b", i, ifc.granted_master);
      chk($sformatf("q_keep%0d", i), 32'(ifc.granted_master), 32'h1);
    end
`endif

    // Random phase against the model.
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0]   r_req;
      logic [N-1:0]   r_lock;
      logic [N-1:0]   r_cs;
      logic [3*N-1:0] r_pri;
      logic           r_rdy;
      logic           r_rst;
      r_req = N'($urandom);
      r_cs  = N'($urandom);
      for (int m = 0; m < N; m++) begin
        r_lock[m]        = ($urandom_range(0, 5) == 0);
        r_pri[3*m +: 3]  = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7))
                                                        : 3'($urandom_range(4, 5));
      end
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rst = ($urandom_range(0, 99) == 0);
      drive(r_rdy, r_req, r_pri, r_lock, r_cs);
      tick(r_rst);
      $display("rnd %0d: req=%b rdy=%b rst=%b gm=%b idx=%0d chg=%b", c, r_req, r_rdy, r_rst,
               ifc.granted_master, ifc.grant_idx, ifc.grant_change);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
